// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered serial transmitter (idle high, start, N_BITS data LSB first, [parity], stop).
// Latency: a word pushed into an empty FIFO at edge k puts the start bit on tx_data after edge k+1.
// Backpressure: in_ready drops while the FIFO holds FIFO_DEPTH words; the producer holds its word.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
// Ports: clk; rst (async, active-low); in_data/in_valid/in_ready upstream handshake;
//    tx_data registered serial line; busy = frame in progress; fifo_count = words buffered.
module uart_tx #(
   parameter int CLKS_PER_BIT = 217,
   parameter int N_BITS       = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_BITS-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        tx_data,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(N_BITS + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_BITS - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   localparam logic ODD_PARITY = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ---------------- FIFO ----------------
   logic [N_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;
   logic              pop;
   logic [N_BITS-1:0] head;

   assign in_ready = (fifo_count != COUNT_FULL);
   assign push     = in_valid & in_ready;
   assign head     = mem[rd_ptr];

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- Frame FSM ----------------
   state_t            state, state_nxt;
   logic [TW-1:0]     timer, timer_nxt;
   logic [IW-1:0]     bit_idx, idx_nxt;
   logic [N_BITS-1:0] shift_reg, shift_nxt;
   logic              tx_nxt;
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              par_bit, par_nxt;
`endif

   assign bit_end = (timer == TIMER_LAST);
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx_data   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         bit_idx   <= idx_nxt;
         shift_reg <= shift_nxt;
         tx_data   <= tx_nxt;
`ifdef UART_TX_PARITY_EN
         par_bit   <= par_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      idx_nxt   = bit_idx;
      shift_nxt = shift_reg;
      pop       = 1'b0;
      tx_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par_bit;
`endif
      if (state != S_IDLE) timer_nxt = bit_end ? '0 : timer + 1'b1;

      case (state)
         S_IDLE:  if (fifo_count != '0) pop = 1'b1;
         S_START: if (bit_end) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
         end
         S_DATA:  if (bit_end) begin
            shift_nxt = shift_reg >> 1;
            idx_nxt   = bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_idx == IDX_LAST) state_nxt = S_PARITY;
`else
            if (bit_idx == IDX_LAST) state_nxt = S_STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (bit_end) state_nxt = S_STOP;
`endif
         // Back-to-back frames: pop at the last stop clock so no idle gap appears.
         S_STOP:  if (bit_end) begin
            if (fifo_count != '0) pop = 1'b1;
            else                  state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (pop) begin
         state_nxt = S_START;
         timer_nxt = '0;
         shift_nxt = head;
`ifdef UART_TX_PARITY_EN
         // Parity is taken at load time because the shift register is consumed during DATA.
         par_nxt   = (^head) ^ ODD_PARITY;
`endif
      end

      // tx_data is registered, so its next value is decoded from the next state.
      case (state_nxt)
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_nxt = par_nxt;
`endif
         default:  tx_nxt = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
   localparam int CPB = 3;
`ifdef UART_TX_PARITY_EN
   localparam int NB_FRAME = 11;
`else
   localparam int NB_FRAME = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx_data;
   logic       busy;
   logic [2:0] fifo_count;

   uart_tx #(.CLKS_PER_BIT(CPB), .N_BITS(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .tx_data(tx_data), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Directed vectors: data, hand-written 10-bit frame (bit 0 = start, bit 9 = stop), even parity.
   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic       par;
   } vec_t;
   vec_t vecs[6];

   // Line receiver: samples each bit in its middle clock, abandons a frame on reset.
   typedef struct {
      logic [7:0] data;
      int         start;
      logic       stop_ok;
   } rx_t;
   rx_t        rx_q[$];
   logic [10:0] rbits;
   logic        aborted;
   int          st_r;

   initial begin
      forever begin
         @(negedge clk);
         if (rst && tx_data == 1'b0) begin
            st_r    = cyc;
            aborted = 1'b0;
            rbits   = '0;
            for (int b = 0; b < NB_FRAME - 1 && !aborted; b++) begin
               for (int k = 0; k < ((b == 0) ? 4 : 3) && !aborted; k++) begin
                  @(negedge clk);
                  if (!rst) aborted = 1'b1;
               end
               rbits[b] = tx_data;
            end
            if (!aborted) rx_q.push_back('{rbits[7:0], st_r, rbits[NB_FRAME-2]});
         end
      end
   end

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int bound);
      int k = 0;
      while (rx_q.size() < n && k < bound) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      check(name, busy, 0);
   endtask

   logic [10:0]  exp_seq;
   int           mism, bcnt, n;
   logic [7:0]   acc_q[$];

   initial begin
      vecs[0] = '{8'hA5, 10'h34A, 1'b0};
      vecs[1] = '{8'h3C, 10'h278, 1'b0};
      vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
      vecs[3] = '{8'h00, 10'h200, 1'b0};
      vecs[4] = '{8'hA4, 10'h348, 1'b1};
      vecs[5] = '{8'h01, 10'h202, 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tx", tx_data, 1);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 1);
      check("rst_count", fifo_count, 0);
      rst = 1'b1;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx_data !== 1'b1) n++;
      end
      check("idle_line_low", n, 0);

      // Single frames, sample-exact.
      for (int v = 0; v < 6; v++) begin
`ifdef UART_TX_PARITY_EN
         exp_seq = {1'b1, vecs[v].par, vecs[v].frame[8:0]};
`else
         exp_seq = {1'b1, vecs[v].frame};
`endif
         push(vecs[v].data);
         @(negedge clk);
         check("pop_lat_tx", tx_data, 1);
         check("pop_lat_busy", busy, 0);
         mism = 0;
         bcnt = 0;
         for (int s = 0; s < NB_FRAME * CPB; s++) begin
            @(negedge clk);
            if (tx_data !== exp_seq[s / CPB]) mism++;
            if (busy) bcnt++;
         end
         check($sformatf("frame_%0h_bad_samples", vecs[v].data), mism, 0);
         check("busy_len", bcnt, NB_FRAME * CPB);
         @(negedge clk);
         check("end_busy", busy, 0);
         check("end_count", fifo_count, 0);
         check("end_tx", tx_data, 1);
      end

      // Back-to-back frames, no idle gap.
      rx_q.delete();
      push(8'h3C); push(8'hFF); push(8'h00);
      wait_rx(3, 400);
      check("b2b_frames", rx_q.size(), 3);
      if (rx_q.size() >= 3) begin
         check("b2b_d0", rx_q[0].data, 8'h3C);
         check("b2b_d1", rx_q[1].data, 8'hFF);
         check("b2b_d2", rx_q[2].data, 8'h00);
         check("b2b_stop", {rx_q[0].stop_ok, rx_q[1].stop_ok, rx_q[2].stop_ok}, 3'b111);
         check("b2b_gap01", rx_q[1].start - rx_q[0].start, NB_FRAME * CPB);
         check("b2b_gap12", rx_q[2].start - rx_q[1].start, NB_FRAME * CPB);
      end
      wait_idle("b2b_idle");

      // Hold in_valid for 8 clocks: FIFO fills, extra words are refused.
      rx_q.delete();
      acc_q.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_data  = 8'(8'h10 + i);
         in_valid = 1'b1;
         if (in_ready) acc_q.push_back(in_data);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("full_accepted", acc_q.size(), 5);
      check("full_count", fifo_count, 4);
      check("full_ready", in_ready, 0);
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ready_rise_delay", n, NB_FRAME * CPB - 6);
      check("ready_rise_count", fifo_count, 3);
      wait_rx(5, 600);
      check("full_frames", rx_q.size(), 5);
      for (int i = 0; i < 5 && i < rx_q.size(); i++)
         check($sformatf("full_d%0d", i), rx_q[i].data, 8'(8'h10 + i));
      wait_idle("full_idle");

      // Reset in the 4th data bit aborts the frame and flushes the FIFO.
      push(8'h52); push(8'h66);
      repeat (14) @(negedge clk);
      check("pre_rst_d3", tx_data, 0);
      check("pre_rst_count", fifo_count, 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_tx", tx_data, 1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", in_ready, 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rx_q.delete();
      push(8'hC3);
      wait_rx(1, 200);
      wait_idle("post_rst_idle");
      repeat (10) @(negedge clk);
      check("post_rst_frames", rx_q.size(), 1);
      if (rx_q.size() >= 1) begin
         check("post_rst_data", rx_q[0].data, 8'hC3);
         check("post_rst_stop", rx_q[0].stop_ok, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
